// File: rtl/haze_pkg.sv
// Shared constants and helpers for the haze-removal pipe.
// sat_u clamps a wide signed value into an unsigned range of a given bit width.
package haze_pkg;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned INV_T_W    = 16;
    localparam int unsigned INV_T_FRAC = 14;
    localparam int unsigned NCH_RGB    = 3;
    localparam int unsigned SAT_W      = 48;

    // Clamp signed r to [0, 2^dw-1]; caller truncates the result to dw bits.
    function automatic logic [SAT_W-1:0] sat_u(input logic signed [SAT_W-1:0] r,
                                               input int unsigned dw);
        logic signed [SAT_W-1:0] max_v;
        max_v = (SAT_W'(1) << dw) - SAT_W'(1);
        if (r[SAT_W-1]) begin
            sat_u = '0;
        end else if (r > max_v) begin
            sat_u = max_v;
        end else begin
            sat_u = r;
        end
    endfunction

endpackage

// File: rtl/srr_channel_mac.sv
// Per-channel datapath of the radiance recovery: capture, multiply by inv_t,
// round/scale, add atmospheric light and clamp. Load enables come from the shared flow control.
import haze_pkg::*;

module srr_channel_mac #(
    parameter int unsigned DW    = PIX_W,
    parameter int unsigned IW    = INV_T_W,
    parameter int unsigned FRAC  = INV_T_FRAC,
    parameter int unsigned ROUND = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ld1,
    input  logic          i_ld2,
    input  logic          i_ld3,
    input  logic [DW:0]   i_diff,
    input  logic [DW-1:0] i_atm,
    input  logic [IW-1:0] i_inv_t,
    output logic [DW-1:0] o_pix
);

    localparam int unsigned PW = DW + IW + 2;
    localparam int unsigned RW = PW + 1;
    localparam logic signed [PW-1:0] RND_C =
        (ROUND != 0 && FRAC > 0) ? (PW'(1) << (FRAC - 1)) : '0;

    logic [DW:0]            r_diff1;
    logic [DW-1:0]          r_atm1;
    logic signed [PW-1:0]   r_p2;
    logic [DW-1:0]          r_atm2;
    logic [DW-1:0]          r_pix;

    logic signed [PW-1:0]   w_p;
    logic signed [PW-1:0]   w_s;
    logic signed [RW-1:0]   w_r;
    logic [DW-1:0]          w_pix;

    // inv_t is zero-extended so it multiplies as a non-negative signed operand.
    assign w_p   = PW'($signed(r_diff1)) * PW'($signed({1'b0, i_inv_t}));
    assign w_s   = (r_p2 + RND_C) >>> FRAC;
    assign w_r   = $signed({w_s[PW-1], w_s}) + $signed({{(RW-DW){1'b0}}, r_atm2});
    assign w_pix = DW'(sat_u(SAT_W'(w_r), DW));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff1 <= '0;
            r_atm1  <= '0;
            r_p2    <= '0;
            r_atm2  <= '0;
            r_pix   <= '0;
        end else begin
            if (i_ld1) begin
                r_diff1 <= i_diff;
                r_atm1  <= i_atm;
            end
            if (i_ld2) begin
                r_p2   <= w_p;
                r_atm2 <= r_atm1;
            end
            if (i_ld3) begin
                r_pix <= w_pix;
            end
        end
    end

    assign o_pix = r_pix;

endmodule

// File: rtl/scene_radiance_recover.sv
// Scene-radiance recovery J_c = sat(A_c + (I_c - A_c) * inv_t) over NCH lanes.
// Three-stage ready/valid pipeline; one flow-control chain drives every channel datapath.
import haze_pkg::*;

module scene_radiance_recover #(
    parameter int unsigned NCH   = NCH_RGB,
    parameter int unsigned DW    = PIX_W,
    parameter int unsigned IW    = INV_T_W,
    parameter int unsigned FRAC  = INV_T_FRAC,
    parameter int unsigned ROUND = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*(DW+1)-1:0] diff,
    input  logic [NCH*DW-1:0]     atm,
    input  logic [IW-1:0]         inv_t,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*DW-1:0]     pix
);

    logic          r_v1;
    logic          r_v2;
    logic          r_v3;
    logic [IW-1:0] r_inv1;

    logic w_rdy1;
    logic w_rdy2;
    logic w_rdy3;
    logic w_ld1;
    logic w_ld2;
    logic w_ld3;

    // A stage may advance when it is empty or the stage after it advances.
    assign w_rdy3 = ~r_v3 | out_ready;
    assign w_rdy2 = ~r_v2 | w_rdy3;
    assign w_rdy1 = ~r_v1 | w_rdy2;

    assign w_ld1 = in_valid & w_rdy1;
    assign w_ld2 = r_v1 & w_rdy2;
    assign w_ld3 = r_v2 & w_rdy3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_inv1 <= '0;
        end else begin
            if (w_rdy1) r_v1 <= in_valid;
            if (w_rdy2) r_v2 <= r_v1;
            if (w_rdy3) r_v3 <= r_v2;
            if (w_ld1)  r_inv1 <= inv_t;
        end
    end

    assign in_ready  = w_rdy1;
    assign out_valid = r_v3;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        srr_channel_mac #(
            .DW    (DW),
            .IW    (IW),
            .FRAC  (FRAC),
            .ROUND (ROUND)
        ) u_mac (
            .clk     (clk),
            .rst     (rst),
            .i_ld1   (w_ld1),
            .i_ld2   (w_ld2),
            .i_ld3   (w_ld3),
            .i_diff  (diff[c*(DW+1) +: DW+1]),
            .i_atm   (atm[c*DW +: DW]),
            .i_inv_t (r_inv1),
            .o_pix   (pix[c*DW +: DW])
        );
    end

endmodule

// File: tb/tb_scene_radiance_recover.sv
// Scoreboard bench for scene_radiance_recover: a round-to-nearest and a floor instance
// share stimulus; a monitor pops expected pixels on every output transfer.
module tb_scene_radiance_recover;

    localparam int unsigned NCH = 3;
    localparam int unsigned DW  = 8;
    localparam int unsigned IW  = 16;
    localparam int unsigned DV  = NCH * (DW + 1);
    localparam int unsigned PV  = NCH * DW;

    typedef struct {
        logic [PV-1:0] pix;
        int            t;
        bit            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready_r;
    logic          in_ready_f;
    logic [DV-1:0] diff;
    logic [PV-1:0] atm;
    logic [IW-1:0] inv_t;
    logic          out_valid_r;
    logic          out_valid_f;
    logic          out_ready;
    logic [PV-1:0] pix_r;
    logic [PV-1:0] pix_f;

    exp_t q_r[$];
    exp_t q_f[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    scene_radiance_recover #(.NCH(NCH), .DW(DW), .IW(IW), .FRAC(14), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .diff(diff), .atm(atm), .inv_t(inv_t),
        .out_valid(out_valid_r), .out_ready(out_ready), .pix(pix_r)
    );

    scene_radiance_recover #(.NCH(NCH), .DW(DW), .IW(IW), .FRAC(14), .ROUND(0)) dut_f (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
        .diff(diff), .atm(atm), .inv_t(inv_t),
        .out_valid(out_valid_f), .out_ready(out_ready), .pix(pix_f)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [DV-1:0] pk_d(input int d0, input int d1, input int d2);
        logic [DV-1:0] v;
        v = {9'(d2), 9'(d1), 9'(d0)};
        return v;
    endfunction

    function automatic logic [PV-1:0] pk_a(input int a0, input int a1, input int a2);
        logic [PV-1:0] v;
        v = {8'(a2), 8'(a1), 8'(a0)};
        return v;
    endfunction

    // Reference: floor((d*it + bias) / 2^14) with integer division, then add and clamp.
    function automatic int model(input int d, input int a, input int it, input bit rnd);
        longint p, n, s, r;
        p = longint'(d) * longint'(it);
        n = p + (rnd ? 64'sd8192 : 64'sd0);
        if (n >= 0) s = n / 16384;
        else        s = -((-n + 16383) / 16384);
        r = longint'(a) + s;
        if (r < 0)   return 0;
        if (r > 255) return 255;
        return int'(r);
    endfunction

    // out_ready pattern: 0 always ready, 1 never ready, 2 random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        bit            ps_r, ps_f;
        logic [PV-1:0] hp_r, hp_f;
        exp_t          e;
        ps_r = 1'b0;
        ps_f = 1'b0;
        hp_r = '0;
        hp_f = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                ps_r = 1'b0;
                ps_f = 1'b0;
            end else begin
                if (ps_r) begin
                    chk("stall_valid_r", longint'(out_valid_r), 1);
                    chk("stall_pix_r", longint'(pix_r), longint'(hp_r));
                end
                if (ps_f) begin
                    chk("stall_valid_f", longint'(out_valid_f), 1);
                    chk("stall_pix_f", longint'(pix_f), longint'(hp_f));
                end
                if (out_valid_r && out_ready) begin
                    if (q_r.size() == 0) begin
                        chk("unexpected_out_r", longint'(pix_r), -1);
                    end else begin
                        e = q_r.pop_front();
                        chk("pix_round", longint'(pix_r), longint'(e.pix));
                        if (e.lat) chk("latency_r", longint'(cyc - e.t), 3);
                    end
                end
                if (out_valid_f && out_ready) begin
                    if (q_f.size() == 0) begin
                        chk("unexpected_out_f", longint'(pix_f), -1);
                    end else begin
                        e = q_f.pop_front();
                        chk("pix_floor", longint'(pix_f), longint'(e.pix));
                        if (e.lat) chk("latency_f", longint'(cyc - e.t), 3);
                    end
                end
                ps_r = out_valid_r && !out_ready;
                ps_f = out_valid_f && !out_ready;
                hp_r = pix_r;
                hp_f = pix_f;
            end
        end
    end

    task automatic send(input logic [DV-1:0] d, input logic [PV-1:0] a, input logic [IW-1:0] it,
                        input logic [PV-1:0] er, input logic [PV-1:0] ef, input bit lat);
        bit   done;
        exp_t e;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        diff     = d;
        atm      = a;
        inv_t    = it;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (in_ready_r) begin
                e.t   = cyc;
                e.lat = lat;
                e.pix = er;
                q_r.push_back(e);
                e.pix = ef;
                q_f.push_back(e);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int k;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while ((q_r.size() != 0 || q_f.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_left", longint'(q_r.size() + q_f.size()), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_model(input bit lat);
        logic [DV-1:0] d;
        logic [PV-1:0] a, er, ef;
        logic [IW-1:0] it;
        int            dv, av;
        it = IW'($urandom_range(0, 65535));
        for (int c = 0; c < NCH; c++) begin
            dv = int'($urandom_range(0, 510)) - 255;
            av = int'($urandom_range(0, 255));
            d[c*9 +: 9]  = 9'(dv);
            a[c*8 +: 8]  = 8'(av);
            er[c*8 +: 8] = 8'(model(dv, av, int'(it), 1'b1));
            ef[c*8 +: 8] = 8'(model(dv, av, int'(it), 1'b0));
        end
        send(d, a, it, er, ef, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        diff     = '0;
        atm      = '0;
        inv_t    = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", longint'(out_valid_r), 0);
        chk("rst_pix", longint'(pix_r), 0);
        chk("rst_pix_f", longint'(pix_f), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", longint'(in_ready_r), 1);

        // Directed vectors, lanes packed {ch2, ch1, ch0}
        send(pk_d(-100, -100, -100), pk_a(200, 200, 200), 16'h6000,
             pk_a(50, 50, 50), pk_a(50, 50, 50), 1'b1);
        send(pk_d(50, 50, 50), pk_a(250, 250, 250), 16'h8000,
             pk_a(255, 255, 255), pk_a(255, 255, 255), 1'b1);
        send(pk_d(-250, -250, -250), pk_a(250, 250, 250), 16'hFFFF,
             pk_a(0, 0, 0), pk_a(0, 0, 0), 1'b1);
        send(pk_d(1, -1, 0), pk_a(10, 10, 10), 16'h2000,
             pk_a(11, 10, 10), pk_a(10, 9, 10), 1'b1);
        send(pk_d(-100, 50, 0), pk_a(200, 250, 77), 16'h6000,
             pk_a(50, 255, 77), pk_a(50, 255, 77), 1'b1);
        send(pk_d(-100, 50, 255), pk_a(200, 3, 0), 16'h0000,
             pk_a(200, 3, 0), pk_a(200, 3, 0), 1'b1);
        send(pk_d(255, -255, -3), pk_a(0, 255, 100), 16'h4000,
             pk_a(255, 0, 97), pk_a(255, 0, 97), 1'b1);
        send(pk_d(-3, 3, -1), pk_a(100, 100, 0), 16'h2000,
             pk_a(99, 102, 0), pk_a(98, 101, 0), 1'b1);
        drain();

        // Random backpressure stream against the reference model
        rdy_mode = 2;
        for (int i = 0; i < 20; i++) send_model(1'b0);
        drain();
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) send_model(1'b1);
        drain();

        // Fill the stalled pipe, then reset for one cycle
        rdy_mode = 1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) send_model(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", longint'(in_ready_r), 0);
        rst = 1'b1;
        q_r.delete();
        q_f.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid_r), 0);
        chk("midrst_out_valid_f", longint'(out_valid_f), 0);
        chk("midrst_pix", longint'(pix_r), 0);
        chk("midrst_in_ready", longint'(in_ready_r), 1);
        rdy_mode = 0;
        send(pk_d(-100, 50, 0), pk_a(200, 250, 77), 16'h6000,
             pk_a(50, 255, 77), pk_a(50, 255, 77), 1'b0);
        drain();
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
